// File: rtl/ffa2_postproc.sv
// -----------------------------------------------------------------------------
// ffa2_postproc
//   Post-processing stage of a 2-parallel fast FIR (FFA). Takes one triple of
//   sub-filter results (H0, H1, H0+H1) and recombines it into an even and an
//   odd output sample:
//     even = y0 + y1 (previous triple)
//     odd  = y01 - y0 - y1
//   Each sample is rounded (round half up, then shifted right by SHIFT) and
//   saturated to DWIDTH. The two samples are then sent one after the other on
//   a single output stream, even sample first.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid/ready  triple handshake (y0_in, y1_in, y01_in, DDWIDTH signed)
//   data_out        serialised DWIDTH signed sample
//   out_valid/ready output handshake
//   sat_flag        sticky: set once any sample has been clamped
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A valid source holds its data stable until it is taken. in_ready
// depends only on the state and out_ready, never on in_valid.
// -----------------------------------------------------------------------------
module ffa2_postproc #(
  parameter int DWIDTH  = 16,
  parameter int DDWIDTH = 2 * DWIDTH,
  parameter int SHIFT   = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DDWIDTH-1:0] y0_in,
  input  logic signed [DDWIDTH-1:0] y1_in,
  input  logic signed [DDWIDTH-1:0] y01_in,
  output logic signed [DWIDTH-1:0]  data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sat_flag
);

  // Two guard bits: the sum of two operands needs one extra bit, and
  // y01 - y0 - y1 needs two.
  localparam int EW = DDWIDTH + 2;

  localparam logic signed [EW-1:0] RND  = EW'(1) << (SHIFT - 1);
  localparam logic signed [EW-1:0] MAXV = {{(EW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EMIT_EVEN = 2'd1,
    EMIT_ODD  = 2'd2
  } state_t;

  state_t                    state_q;
  logic signed [DDWIDTH-1:0] y1_dly_q;   // y1 of the previously accepted triple
  logic signed [DWIDTH-1:0]  even_q;
  logic signed [DWIDTH-1:0]  odd_q;
  logic                      out_valid_q;
  logic                      sat_q;

  logic                      accept;
  logic signed [EW-1:0]      y0_x;
  logic signed [EW-1:0]      y1_x;
  logic signed [EW-1:0]      y01_x;
  logic signed [EW-1:0]      y1_dly_x;
  logic signed [EW-1:0]      even_x;
  logic signed [EW-1:0]      odd_x;
  logic [DWIDTH:0]           even_rs;    // {clamped, sample}
  logic [DWIDTH:0]           odd_rs;

  // Round half up, arithmetic shift, then clamp. The MSB of the result flags
  // that clamping took place.
  function automatic logic [DWIDTH:0] round_sat(input logic signed [EW-1:0] x);
    logic signed [EW-1:0] r;
    r = (x + RND) >>> SHIFT;
    if (r > MAXV) begin
      return {1'b1, MAXV[DWIDTH-1:0]};
    end else if (r < MINV) begin
      return {1'b1, MINV[DWIDTH-1:0]};
    end
    return {1'b0, r[DWIDTH-1:0]};
  endfunction

  assign in_ready = (state_q == IDLE) | ((state_q == EMIT_ODD) & out_ready);
  assign accept   = in_valid & in_ready;

  // Explicit sign extension to the internal width.
  assign y0_x     = {{2{y0_in[DDWIDTH-1]}}, y0_in};
  assign y1_x     = {{2{y1_in[DDWIDTH-1]}}, y1_in};
  assign y01_x    = {{2{y01_in[DDWIDTH-1]}}, y01_in};
  assign y1_dly_x = {{2{y1_dly_q[DDWIDTH-1]}}, y1_dly_q};

  assign even_x  = y0_x + y1_dly_x;
  assign odd_x   = y01_x - y0_x - y1_x;
  assign even_rs = round_sat(even_x);
  assign odd_rs  = round_sat(odd_x);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      y1_dly_q    <= '0;
      even_q      <= '0;
      odd_q       <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      if (accept) begin
        y1_dly_q <= y1_in;
        even_q   <= even_rs[DWIDTH-1:0];
        odd_q    <= odd_rs[DWIDTH-1:0];
        if (even_rs[DWIDTH] | odd_rs[DWIDTH]) begin
          sat_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= EMIT_EVEN;
            out_valid_q <= 1'b1;
          end
        end
        EMIT_EVEN: begin
          if (out_ready) begin
            state_q <= EMIT_ODD;
          end
        end
        EMIT_ODD: begin
          if (out_ready) begin
            // A triple arriving with the odd handshake goes straight to the
            // next even sample, so a steady stream has no bubble.
            if (accept) begin
              state_q <= EMIT_EVEN;
            end else begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Selection between two registers by the registered state: no path from
  // any input reaches data_out. It reads 0 after reset because even_q does.
  assign data_out  = (state_q == EMIT_ODD) ? odd_q : even_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_q;

endmodule
